// File: rtl/keypad_event_encoder_if.sv
// Keypad bundle: raw key lines towards the encoder, encoded event, clear and
// held status back towards the calculator core.
interface keypad_event_encoder_if;
   logic [15:0] pb;
   logic [4:0]  eBCD;
   logic        clr;
   logic        key_held;

   modport master (output pb, input eBCD, clr, key_held);
   modport slave  (input pb, output eBCD, clr, key_held);
endinterface

// File: rtl/keypad_event_encoder.sv
// Keypad scanner: resynchronises the key lines, debounces single-key presses on
// a slow sample tick and emits one extended-BCD strobe (or a clear pulse) per press.
module keypad_event_encoder #(
   parameter int TICK_DIV   = 50_000,
   parameter int DEB_TICKS  = 20,
   parameter int STROBE_CYC = 8
) (
   input  logic                  clock_50m,
   input  logic                  rst,
   keypad_event_encoder_if.slave kp
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int CW = $clog2(DEB_TICKS + 1);
   localparam int SW = $clog2(STROBE_CYC + 1);

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_TICKS);
   localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYC);
   localparam logic [3:0]    CLEAR_KEY   = 4'hD;

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      EMIT,
      HOLD,
      RELEASE
   } state_e;

   state_e          state_q,      state_d;
   logic [15:0]     sync1_q,      sync1_d;
   logic [15:0]     sync2_q,      sync2_d;
   logic [TW-1:0]   tick_cnt_q,   tick_cnt_d;
   logic [3:0]      cand_q,       cand_d;
   logic [CW-1:0]   deb_cnt_q,    deb_cnt_d;
   logic [CW-1:0]   rel_cnt_q,    rel_cnt_d;
   logic [SW-1:0]   strobe_cnt_q, strobe_cnt_d;
   logic [4:0]      ebcd_q,       ebcd_d;
   logic            clr_q,        clr_d;
   logic            key_held_q,   key_held_d;

   logic            tick;
   logic [15:0]     sample;
   logic            sample_onehot;
   logic            sample_zero;
   logic [3:0]      sample_idx;
   logic [15:0]     cand_mask;
   logic [CW-1:0]   deb_inc;
   logic [CW-1:0]   rel_inc;
   logic            accept;
   logic [3:0]      accept_code;
   logic            release_key;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      sync1_d    = kp.pb;
      sync2_d    = sync1_q;
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   assign sample        = sync2_q;
   assign sample_onehot = $onehot(sample);
   assign sample_zero   = (sample == '0);
   assign cand_mask     = 16'h0001 << cand_q;
   assign deb_inc       = deb_cnt_q + CW'(1);
   assign rel_inc       = rel_cnt_q + CW'(1);

   // Only consulted when the sample is onehot, so scan order does not matter.
   always_comb begin
      sample_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (sample[i]) sample_idx = 4'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      deb_cnt_d    = deb_cnt_q;
      rel_cnt_d    = rel_cnt_q;
      strobe_cnt_d = strobe_cnt_q;
      ebcd_d       = ebcd_q;
      clr_d        = 1'b0;
      key_held_d   = key_held_q;
      accept       = 1'b0;
      accept_code  = cand_q;
      release_key  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tick && sample_onehot) begin
               cand_d = sample_idx;
               if (DEB_TICKS == 1) begin
                  accept      = 1'b1;
                  accept_code = sample_idx;
               end else begin
                  deb_cnt_d = CW'(1);
                  state_d   = DEBOUNCE;
               end
            end
         end

         DEBOUNCE: begin
            if (tick) begin
               if (sample == cand_mask) begin
                  if (deb_inc == DEB_LAST) accept = 1'b1;
                  else                     deb_cnt_d = deb_inc;
               end else begin
                  // A different key on this tick is not captured; it must
                  // start over from IDLE on a later tick.
                  deb_cnt_d = '0;
                  state_d   = IDLE;
               end
            end
         end

         EMIT: begin
            if (strobe_cnt_q == STROBE_LAST) begin
               ebcd_d[4]    = 1'b0;
               strobe_cnt_d = '0;
               state_d      = HOLD;
            end else begin
               strobe_cnt_d = strobe_cnt_q + SW'(1);
            end
         end

         HOLD: begin
            if (tick && sample_zero) begin
               if (DEB_TICKS == 1) begin
                  release_key = 1'b1;
               end else begin
                  rel_cnt_d = CW'(1);
                  state_d   = RELEASE;
               end
            end
         end

         RELEASE: begin
            if (tick) begin
               if (!sample_zero) begin
                  rel_cnt_d = '0;
                  state_d   = HOLD;
               end else if (rel_inc == DEB_LAST) begin
                  release_key = 1'b1;
               end else begin
                  rel_cnt_d = rel_inc;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (accept) begin
         deb_cnt_d  = '0;
         key_held_d = 1'b1;
         if (accept_code == CLEAR_KEY) begin
            // Clear never touches eBCD, so the last code stays visible.
            clr_d   = 1'b1;
            state_d = HOLD;
         end else begin
            ebcd_d       = {1'b1, accept_code};
            strobe_cnt_d = SW'(1);
            state_d      = EMIT;
         end
      end

      if (release_key) begin
         rel_cnt_d  = '0;
         key_held_d = 1'b0;
         state_d    = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge clock_50m or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sync1_q      <= '0;
         sync2_q      <= '0;
         tick_cnt_q   <= '0;
         cand_q       <= '0;
         deb_cnt_q    <= '0;
         rel_cnt_q    <= '0;
         strobe_cnt_q <= '0;
         ebcd_q       <= '0;
         clr_q        <= 1'b0;
         key_held_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         tick_cnt_q   <= tick_cnt_d;
         cand_q       <= cand_d;
         deb_cnt_q    <= deb_cnt_d;
         rel_cnt_q    <= rel_cnt_d;
         strobe_cnt_q <= strobe_cnt_d;
         ebcd_q       <= ebcd_d;
         clr_q        <= clr_d;
         key_held_q   <= key_held_d;
      end
   end

   assign kp.eBCD     = ebcd_q;
   assign kp.clr      = clr_q;
   assign kp.key_held = key_held_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Bench for keypad_event_encoder: a DEB_TICKS=3 build and a DEB_TICKS=1 build
// share one key stream and are both compared every cycle against a press/release model.
module tb_keypad_event_encoder;

   localparam int TD = 4;
   localparam int DT = 3;
   localparam int SC = 2;

   logic clk = 1'b0;
   logic rst;

   keypad_event_encoder_if kp3();
   keypad_event_encoder_if kp1();

   keypad_event_encoder #(.TICK_DIV(TD), .DEB_TICKS(DT), .STROBE_CYC(SC)) u_dut3 (
      .clock_50m (clk),
      .rst       (rst),
      .kp        (kp3)
   );

   keypad_event_encoder #(.TICK_DIV(TD), .DEB_TICKS(1), .STROBE_CYC(SC)) u_dut1 (
      .clock_50m (clk),
      .rst       (rst),
      .kp        (kp1)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model of each build (index 0: DEB_TICKS=3, index 1: DEB_TICKS=1).
   int          m_deb [2] = '{DT, 1};
   logic [15:0] m_hist [$];
   int          m_edge;
   bit          m_held [2];
   int          m_cand [2];
   int          m_run  [2];
   int          m_zrun [2];
   int          m_left [2];
   logic [3:0]  m_code [2];
   bit          m_clr  [2];

   int ev_rise [2];
   int clr_cyc [2];
   bit prev_strobe [2];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int onehot_index(input logic [15:0] v);
      int idx = 0;
      for (int i = 0; i < 16; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_edge = 0;
      for (int k = 0; k < 2; k++) begin
         m_held[k] = 0; m_cand[k] = 0; m_run[k] = 0; m_zrun[k] = 0;
         m_left[k] = 0; m_code[k] = 4'h0; m_clr[k] = 0;
      end
   endtask

   // One clock edge: the key lines seen here were driven two edges earlier, and
   // only every TD-th edge carries a sample.
   task automatic model_edge(input logic [15:0] pb_now);
      logic [15:0] smp;
      bit          tick;
      smp  = (m_hist.size() == 2) ? m_hist[0] : 16'h0000;
      tick = ((m_edge % TD) == TD - 1);
      m_hist.push_back(pb_now);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      m_edge++;
      for (int k = 0; k < 2; k++) begin
         m_clr[k] = 0;
         if (!m_held[k]) begin
            if (tick) begin
               if (m_run[k] > 0) begin
                  if (smp == (16'h0001 << m_cand[k])) m_run[k]++;
                  else                                m_run[k] = 0;
               end else if ($countones(smp) == 1) begin
                  m_cand[k] = onehot_index(smp);
                  m_run[k]  = 1;
               end
            end
            if (m_run[k] == m_deb[k]) begin
               m_run[k]  = 0;
               m_held[k] = 1;
               if (m_cand[k] == 13) begin
                  m_clr[k] = 1;
               end else begin
                  m_code[k] = 4'(m_cand[k]);
                  m_left[k] = SC;
               end
            end
         end else if (m_left[k] > 0) begin
            m_left[k]--;
         end else if (tick) begin
            if (smp == 16'h0000) m_zrun[k]++;
            else                 m_zrun[k] = 0;
            if (m_zrun[k] == m_deb[k]) begin
               m_held[k] = 0;
               m_zrun[k] = 0;
            end
         end
      end
   endtask

   function automatic logic [4:0] get_ebcd(input int k);
      return (k == 0) ? kp3.eBCD : kp1.eBCD;
   endfunction

   function automatic logic get_clr(input int k);
      return (k == 0) ? kp3.clr : kp1.clr;
   endfunction

   task automatic compare();
      logic [4:0] e;
      check("ebcd_deb3", 16'(kp3.eBCD),     16'({m_left[0] > 0, m_code[0]}));
      check("clr_deb3",  16'(kp3.clr),      16'(m_clr[0]));
      check("held_deb3", 16'(kp3.key_held), 16'(m_held[0]));
      check("ebcd_deb1", 16'(kp1.eBCD),     16'({m_left[1] > 0, m_code[1]}));
      check("clr_deb1",  16'(kp1.clr),      16'(m_clr[1]));
      check("held_deb1", 16'(kp1.key_held), 16'(m_held[1]));
      for (int k = 0; k < 2; k++) begin
         e = get_ebcd(k);
         if (e[4] && !prev_strobe[k]) ev_rise[k]++;
         prev_strobe[k] = e[4];
         if (get_clr(k)) clr_cyc[k]++;
      end
   endtask

   task automatic step(input logic [15:0] pb_val);
      kp3.pb = pb_val;
      kp1.pb = pb_val;
      @(posedge clk);
      if (!rst) model_edge(pb_val);
      #1;
      compare();
   endtask

   task automatic hold(input logic [15:0] pb_val, input int n);
      for (int i = 0; i < n; i++) step(pb_val);
   endtask

   // Raises reset in the middle of a cycle, checks the outputs clear at once,
   // then releases it just after an edge with pb_val still applied.
   task automatic do_reset(input logic [15:0] pb_val);
      #2 rst = 1'b1;
      #1;
      check("rst_ebcd", 16'(kp3.eBCD),     16'h0000);
      check("rst_held", 16'(kp3.key_held), 16'h0000);
      check("rst_clr",  16'(kp3.clr),      16'h0000);
      model_reset();
      hold(pb_val, 2);
      rst = 1'b0;
   endtask

   int r0, r1, c0;
   logic [15:0] rnd_pb;
   bit seen;

   initial begin
      rst    = 1'b1;
      kp3.pb = '0;
      kp1.pb = '0;
      model_reset();
      hold(16'h0000, 2);
      rst = 1'b0;
      check("init_ebcd", 16'(kp3.eBCD),     16'h0000);
      check("init_held", 16'(kp3.key_held), 16'h0000);

      // Clean press of key 7.
      r0 = ev_rise[0]; c0 = clr_cyc[0];
      hold(16'h0080, 40);
      hold(16'h0000, 40);
      check("clean_events", 16'(ev_rise[0] - r0), 16'd1);
      check("clean_code",   16'(kp3.eBCD),        16'h0007);
      check("clean_clr",    16'(clr_cyc[0] - c0), 16'd0);

      // Key 3 bouncing on every sample tick, then settling.
      r0 = ev_rise[0];
      for (int t = 0; t < 5; t++) hold((t % 2 == 0) ? 16'h0008 : 16'h0000, TD);
      check("bounce_quiet", 16'(ev_rise[0] - r0), 16'd0);
      hold(16'h0008, 20);
      check("bounce_events", 16'(ev_rise[0] - r0), 16'd1);
      check("bounce_code",   16'(kp3.eBCD[3:0]),   16'h0003);
      hold(16'h0000, 40);

      // Clear key: one clr cycle, no strobe, code unchanged.
      r0 = ev_rise[0]; c0 = clr_cyc[0];
      hold(16'h2000, 30);
      check("clear_pulse",  16'(clr_cyc[0] - c0), 16'd1);
      check("clear_strobe", 16'(ev_rise[0] - r0), 16'd0);
      check("clear_code",   16'(kp3.eBCD),        16'h0003);
      check("clear_held",   16'(kp3.key_held),    16'h0001);
      hold(16'h0000, 40);

      // Two keys at once, then a second key while one is held.
      r0 = ev_rise[0];
      hold(16'h0003, 40);
      check("multi_none", 16'(ev_rise[0] - r0), 16'd0);
      hold(16'h0000, 20);
      hold(16'h0020, 30);
      hold(16'h0060, 30);
      check("multi_one",  16'(ev_rise[0] - r0), 16'd1);
      check("multi_code", 16'(kp3.eBCD),        16'h0005);
      hold(16'h0000, 40);
      hold(16'h0040, 30);
      check("fresh_two",  16'(ev_rise[0] - r0), 16'd2);
      check("fresh_code", 16'(kp3.eBCD[3:0]),   16'h0006);
      hold(16'h0000, 40);

      // Reset during the first strobe cycle of key F.
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(16'h8000);
         seen = kp3.eBCD[4];
      end
      check("midrst_strobe_seen", 16'(seen),      16'h0001);
      check("midrst_code",        16'(kp3.eBCD),  16'h001F);
      do_reset(16'h8000);
      r0 = ev_rise[0];
      hold(16'h8000, 30);
      check("postrst_events", 16'(ev_rise[0] - r0), 16'd1);
      check("postrst_code",   16'(kp3.eBCD[3:0]),   16'h000F);
      hold(16'h0000, 40);

      // A press lasting one tick period: only the single-tick build reacts.
      r0 = ev_rise[0]; r1 = ev_rise[1];
      hold(16'h0010, TD);
      hold(16'h0000, 30);
      check("short_deb1", 16'(ev_rise[1] - r1), 16'd1);
      check("short_deb3", 16'(ev_rise[0] - r0), 16'd0);
      check("short_code", 16'(kp1.eBCD),        16'h0004);

      // Randomised key activity, checked cycle by cycle against the model.
      for (int s = 0; s < 300; s++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rnd_pb = 16'h0000;
            4, 5, 6, 7: rnd_pb = 16'h0001 << $urandom_range(0, 15);
            8:          rnd_pb = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default:    rnd_pb = 16'($urandom);
         endcase
         hold(rnd_pb, $urandom_range(1, 24));
         if ($urandom_range(0, 99) == 0) do_reset(rnd_pb);
      end
      hold(16'h0000, 40);
      check("final_idle", 16'(kp3.key_held), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
